coffee_dispenser: RTL and testbench



---
 rtl/coffee_dispenser.sv | 223 ++++++++++++++++++++++
 tb/tb_coffee_dispenser.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coffee_dispenser.sv
// coffee_dispenser: brew-phase sequencer behind the drink selection logic.
// Takes one drink order per handshake. It runs the grind, brew, steam and froth
// phases, and each phase has its own cycle count. It pulses done when a drink is
// finished and keeps a saturating count of cups served.
// Optional feature: define COFFEE_DISPENSER_ABORT_EN to add the abort input and
// the aborted output. When the macro is undefined, every drink that starts runs
// to completion.
module coffee_dispenser #(
    parameter int unsigned GRIND_CYC   = 3,
    parameter int unsigned BREW_CYC    = 8,
    parameter int unsigned LARGE_EXTRA = 4,
    parameter int unsigned MILK_CYC    = 6,
    parameter int unsigned FOAM_CYC    = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        order_valid,
    output logic        order_ready,
    input  logic [1:0]  coffee_type,
    input  logic        size,
`ifdef COFFEE_DISPENSER_ABORT_EN
    input  logic        abort,
    output logic        aborted,
`endif
    output logic        grinder_on,
    output logic        pump_on,
    output logic        steamer_on,
    output logic        frother_on,
    output logic        busy,
    output logic        done,
    output logic        err_none,
    output logic [15:0] cup_count
);

    localparam int unsigned CUP_W = 16;
    localparam int unsigned TYPE_W = 2;

    localparam logic [TYPE_W-1:0] TYPE_NONE       = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] TYPE_ESPRESSO   = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] TYPE_LATTE      = TYPE_W'(2);

    // Counter reload values: a phase of N cycles loads N-1 and exits at zero.
    localparam logic [CNT_W-1:0] GRIND_LAST   = CNT_W'(GRIND_CYC - 1);
    localparam logic [CNT_W-1:0] BREW_S_LAST  = CNT_W'(BREW_CYC - 1);
    localparam logic [CNT_W-1:0] BREW_L_LAST  = CNT_W'(BREW_CYC + LARGE_EXTRA - 1);
    localparam logic [CNT_W-1:0] MILK_LAST    = CNT_W'(MILK_CYC - 1);
    localparam logic [CNT_W-1:0] FOAM_LAST    = CNT_W'(FOAM_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRIND = 3'd1,
        S_BREW  = 3'd2,
        S_MILK  = 3'd3,
        S_FOAM  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    logic                size_q, size_d;
    logic                ready_q;
    logic                grinder_q, pump_q, steamer_q, frother_q;
    logic                busy_q, done_q;
    logic                err_q, err_d;
    logic [CUP_W-1:0]    cup_q, cup_d;
    logic                accept;
    logic                cnt_zero;
    logic [CNT_W-1:0]    brew_last;
`ifdef COFFEE_DISPENSER_ABORT_EN
    logic                abort_hit;
    logic                aborted_q;
`endif

    assign accept    = order_valid && ready_q;
    assign cnt_zero  = (cnt_q == '0);
    assign brew_last = size_q ? BREW_L_LAST : BREW_S_LAST;

    // Next-state, phase counter and order capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        size_d  = size_q;
        err_d   = 1'b0;
`ifdef COFFEE_DISPENSER_ABORT_EN
        abort_hit = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    type_d = coffee_type;
                    size_d = size;
                    if (coffee_type == TYPE_NONE) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_GRIND;
                        cnt_d   = GRIND_LAST;
                    end
                end
            end
            S_GRIND: begin
                if (cnt_zero) begin
                    state_d = S_BREW;
                    cnt_d   = brew_last;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_BREW: begin
                if (cnt_zero) begin
                    if (type_q == TYPE_ESPRESSO) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_MILK;
                        cnt_d   = MILK_LAST;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_MILK: begin
                if (cnt_zero) begin
                    if (type_q == TYPE_LATTE) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_FOAM;
                        cnt_d   = FOAM_LAST;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FOAM: begin
                if (cnt_zero) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef COFFEE_DISPENSER_ABORT_EN
        // Abort only cuts an active phase; IDLE and DONE ignore it
        if (abort && (state_q inside {S_GRIND, S_BREW, S_MILK, S_FOAM})) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            abort_hit = 1'b1;
        end
`endif
    end

    // Saturating served-cup counter, bumped on entry to DONE
    always_comb begin
        cup_d = cup_q;
        if ((state_d == S_DONE) && (state_q != S_DONE) && (cup_q != '1)) begin
            cup_d = cup_q + CUP_W'(1);
        end
    end

    // State and registered Moore outputs, decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            type_q    <= '0;
            size_q    <= 1'b0;
            ready_q   <= 1'b1;
            grinder_q <= 1'b0;
            pump_q    <= 1'b0;
            steamer_q <= 1'b0;
            frother_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cup_q     <= '0;
`ifdef COFFEE_DISPENSER_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            size_q    <= size_d;
            ready_q   <= (state_d == S_IDLE);
            grinder_q <= (state_d == S_GRIND);
            pump_q    <= (state_d == S_BREW);
            steamer_q <= (state_d == S_MILK);
            frother_q <= (state_d == S_FOAM);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            err_q     <= err_d;
            cup_q     <= cup_d;
`ifdef COFFEE_DISPENSER_ABORT_EN
            aborted_q <= abort_hit;
`endif
        end
    end

    assign order_ready = ready_q;
    assign grinder_on  = grinder_q;
    assign pump_on     = pump_q;
    assign steamer_on  = steamer_q;
    assign frother_on  = frother_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_none    = err_q;
    assign cup_count   = cup_q;
`ifdef COFFEE_DISPENSER_ABORT_EN
    assign aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_coffee_dispenser.sv
// Scoreboard bench for coffee_dispenser. Each accepted order pushes its expected
// completion event, which covers cycle, actuator windows and cup count. A negedge
// monitor pops and checks the event when done, err_none or aborted fires.
module tb_coffee_dispenser;

    localparam int G  = 3;
    localparam int B  = 8;
    localparam int LX = 4;
    localparam int M  = 6;
    localparam int F  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        order_valid = 1'b0;
    logic [1:0]  coffee_type = 2'd0;
    logic        size = 1'b0;
    logic        order_ready;
    logic        grinder_on, pump_on, steamer_on, frother_on;
    logic        busy, done, err_none;
    logic [15:0] cup_count;
    logic        ev_abort;
`ifdef COFFEE_DISPENSER_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
    assign ev_abort = aborted;
`else
    assign ev_abort = 1'b0;
`endif

    coffee_dispenser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .order_valid (order_valid),
        .order_ready (order_ready),
        .coffee_type (coffee_type),
        .size        (size),
`ifdef COFFEE_DISPENSER_ABORT_EN
        .abort       (abort),
        .aborted     (aborted),
`endif
        .grinder_on  (grinder_on),
        .pump_on     (pump_on),
        .steamer_on  (steamer_on),
        .frother_on  (frother_on),
        .busy        (busy),
        .done        (done),
        .err_none    (err_none),
        .cup_count   (cup_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 drink done, 1 NONE order, 2 aborted drink
    typedef struct {
        int kind;
        int acc;
        int typ;
        int sz;
        int cup;
        int abc;
    } exp_t;

    exp_t  sb[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    next_free = 0;
    int    exp_cups = 0;
    bit    mon_en = 1'b0;
    int    a_first [4];
    int    a_cnt   [4];
    int    onehot_bad = 0;
    logic [3:0] act;
    string act_nm [4] = '{"grinder", "pump", "steamer", "frother"};

    task automatic chk(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)",
                     tag, $signed(actual), $signed(expected), $time, cyc);
        end
    endtask

    task automatic check_event(input exp_t e);
        int ef [4];
        int en [4];
        int t;
        int bl;
        int seen;
        seen = done ? 0 : (err_none ? 1 : 2);
        chk("event_kind", seen, e.kind);
        for (int i = 0; i < 4; i++) begin
            ef[i] = -1;
            en[i] = 0;
        end
        if (e.kind == 0) begin
            bl = B + (e.sz != 0 ? LX : 0);
            t = e.acc + 1;
            ef[0] = t; en[0] = G;  t += G;
            ef[1] = t; en[1] = bl; t += bl;
            if (e.typ >= 2) begin ef[2] = t; en[2] = M; t += M; end
            if (e.typ == 3) begin ef[3] = t; en[3] = F; t += F; end
            chk("done_cycle", cyc, t);
            for (int i = 0; i < 4; i++) begin
                chk({act_nm[i], "_first"}, a_first[i], ef[i]);
                chk({act_nm[i], "_cycles"}, a_cnt[i], en[i]);
            end
            chk("done_busy", busy, 1);
            chk("done_ready", order_ready, 0);
        end else if (e.kind == 1) begin
            chk("err_cycle", cyc, e.acc + 1);
            for (int i = 0; i < 4; i++) chk({act_nm[i], "_cycles_none"}, a_cnt[i], 0);
            chk("err_busy", busy, 0);
            chk("err_ready", order_ready, 1);
        end else begin
            chk("abort_cycle", cyc, e.abc + 1);
            chk("abort_grind_cycles", a_cnt[0], G);
            chk("abort_pump_cycles", a_cnt[1], e.abc - e.acc - G);
            chk("abort_pump_now", pump_on, 0);
            chk("abort_done", done, 0);
            chk("abort_busy", busy, 0);
            chk("abort_ready", order_ready, 1);
        end
        chk("cup_count", cup_count, e.cup);
    endtask

    // Event monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (!mon_en) begin
            for (int i = 0; i < 4; i++) begin a_first[i] = -1; a_cnt[i] = 0; end
        end else begin
            act = {frother_on, steamer_on, pump_on, grinder_on};
            if ($countones(act) > 1) onehot_bad++;
            for (int i = 0; i < 4; i++) begin
                if (act[i]) begin
                    if (a_first[i] < 0) a_first[i] = cyc;
                    a_cnt[i]++;
                end
            end
            if (done || err_none || ev_abort) begin
                if (sb.size() == 0) chk("unexpected_event", cyc, -1);
                else check_event(sb.pop_front());
                for (int i = 0; i < 4; i++) begin a_first[i] = -1; a_cnt[i] = 0; end
            end
        end
    end

    function automatic int done_cycle(input int t, input int s, input int c);
        return c + G + B + (s != 0 ? LX : 0) + 1 + (t >= 2 ? M : 0) + (t == 3 ? F : 0);
    endfunction

    // Present an order from a negedge; returns at the negedge after acceptance
    task automatic send(input logic [1:0] t, input logic s);
        int   ea;
        exp_t e;
        ea = (cyc > next_free) ? cyc : next_free;
        order_valid = 1'b1;
        coffee_type = t;
        size        = s;
        for (int n = 0; n < 400 && !order_ready; n++) @(negedge clk);
        chk("accept_cycle", cyc, ea);
        e.acc = cyc; e.typ = int'(t); e.sz = int'(s); e.abc = 0;
        if (t == 2'd0) begin
            e.kind = 1; e.cup = exp_cups; next_free = cyc + 1;
        end else begin
            e.kind = 0; exp_cups++; e.cup = exp_cups;
            next_free = done_cycle(int'(t), int'(s), cyc) + 1;
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

`ifdef COFFEE_DISPENSER_ABORT_EN
    // Convert the most recent drink into an expected abort at this cycle
    task automatic mark_abort();
        exp_t e;
        e = sb.pop_back();
        e.kind = 2;
        e.abc  = cyc;
        exp_cups--;
        e.cup  = exp_cups;
        next_free = cyc + 1;
        sb.push_back(e);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", order_ready, 1);
        chk("rst_actuators", {grinder_on, pump_on, steamer_on, frother_on}, 0);
        chk("rst_busy_done_err", {busy, done, err_none}, 0);
        chk("rst_cup", cup_count, 0);
        rst_n = 1'b1;
        next_free = cyc;
        mon_en = 1'b1;
        @(negedge clk);

        send(2'd1, 1'b0); order_valid = 1'b0; drain();  // small espresso
        send(2'd3, 1'b1); order_valid = 1'b0; drain();  // large cappuccino
        send(2'd2, 1'b0); order_valid = 1'b0; drain();  // small latte
        send(2'd0, 1'b0);                               // NONE, then next order straight away
        send(2'd1, 1'b1); order_valid = 1'b0; drain();

        // Reset in the middle of a large latte brew phase
        send(2'd2, 1'b1); order_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_pump", pump_on, 1);
        @(posedge clk); #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_rst_actuators", {grinder_on, pump_on, steamer_on, frother_on}, 0);
        chk("async_rst_busy_done", {busy, done, err_none}, 0);
        chk("async_rst_cup", cup_count, 0);
        chk("async_rst_ready", order_ready, 1);
        sb.delete();
        exp_cups = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        next_free = cyc;
        mon_en = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_cup", cup_count, 0);
        chk("post_rst_busy", busy, 0);

        // Three espressos with order_valid held throughout
        send(2'd1, 1'b0);
        send(2'd1, 1'b0);
        send(2'd1, 1'b0);
        order_valid = 1'b0;
        drain();
        chk("b2b_cup", cup_count, 3);

`ifdef COFFEE_DISPENSER_ABORT_EN
        send(2'd1, 1'b0); order_valid = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        mark_abort();
        @(negedge clk);
        abort = 1'b0;
        drain();
        abort = 1'b1;                                   // ignored while idle
        repeat (3) @(negedge clk);
        abort = 1'b0;
        send(2'd1, 1'b0); order_valid = 1'b0;
        repeat (11) @(negedge clk);
        abort = 1'b1;                                   // ignored in DONE
        @(negedge clk);
        abort = 1'b0;
        drain();
        chk("abort_final_cup", cup_count, 4);
`endif

        chk("actuator_onehot", onehot_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
